// File: rtl/sync_ff_pkg.sv
// sync_ff_pkg: shared sizing helper and occupancy type for the sync_ff FIFO slice
package sync_ff_pkg;
  localparam int FF_DATA_W_DEF = 8;
  localparam int FF_DEPTH_DEF = 16;
  function automatic int ff_addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction
  typedef logic [ff_addr_w(FF_DEPTH_DEF):0] ff_occ_t;
endpackage

// File: rtl/sync_ff_if.sv
// ff_intf: generic FIFO interface; status signals exist only with SYNC_FF_STATUS_EN
interface ff_intf #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16
);
  import sync_ff_pkg::*;
  localparam int ADDR_W = ff_addr_w(DEPTH);
  logic ff_wr_en;
  logic [DATA_W-1:0] ff_wr_data;
  logic ff_rd_en;
  logic ff_full;
  logic ff_empty;
  logic [DATA_W-1:0] ff_rd_data;
`ifdef SYNC_FF_STATUS_EN
  logic [ADDR_W:0] ff_occ;
  logic ff_ovrflw;
  logic ff_undrflw;
  modport ff_slave (
    input ff_wr_en, ff_wr_data, ff_rd_en,
    output ff_full, ff_empty, ff_rd_data, ff_occ, ff_ovrflw, ff_undrflw
  );
`else
  modport ff_slave (
    input ff_wr_en, ff_wr_data, ff_rd_en,
    output ff_full, ff_empty, ff_rd_data
  );
`endif
  modport wr_only (output ff_wr_en, ff_wr_data, input ff_full);
  modport rd_only (output ff_rd_en, input ff_empty, ff_rd_data);
endinterface

// File: rtl/sync_ff_ram.sv
// sync_ff_ram: simple dual-port RAM, one write port and one registered read port
module sync_ff_ram
  import sync_ff_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int ADDR_W = ff_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sync_ff.sv
// sync_ff: single-clock FIFO on the ff_slave modport; SYNC_FF_STATUS_EN adds occupancy and sticky over/underflow
module sync_ff
  import sync_ff_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16
) (
  input logic clk_ir,
  input logic rst_ih,
  ff_intf.ff_slave ff_sl_intf
);
  localparam int ADDR_W = ff_addr_w(DEPTH);
  localparam logic [ADDR_W:0] OCC_FULL = (ADDR_W+1)'(DEPTH);
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0] occ, occ_next;
  logic wr_acc, rd_acc, full, empty;
  always_comb begin
    wr_acc = ff_sl_intf.ff_wr_en && !full;
    rd_acc = ff_sl_intf.ff_rd_en && !empty;
    occ_next = occ + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
  end
  // flags come from next-state occupancy so they are registered yet current
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      wptr <= '0;
      rptr <= '0;
      occ <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr_acc) wptr <= wptr + ADDR_W'(1);
      if (rd_acc) rptr <= rptr + ADDR_W'(1);
      occ <= occ_next;
      full <= occ_next == OCC_FULL;
      empty <= occ_next == '0;
    end
  end
  sync_ff_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk_ir),
    .rst(rst_ih),
    .we(wr_acc),
    .waddr(wptr),
    .wdata(ff_sl_intf.ff_wr_data),
    .re(rd_acc),
    .raddr(rptr),
    .rdata(ff_sl_intf.ff_rd_data)
  );
  assign ff_sl_intf.ff_full = full;
  assign ff_sl_intf.ff_empty = empty;
`ifdef SYNC_FF_STATUS_EN
  logic ovrflw, undrflw;
  always_ff @(posedge clk_ir or posedge rst_ih) begin
    if (rst_ih) begin
      ovrflw <= 1'b0;
      undrflw <= 1'b0;
    end else begin
      if (ff_sl_intf.ff_wr_en && full) ovrflw <= 1'b1;
      if (ff_sl_intf.ff_rd_en && empty) undrflw <= 1'b1;
    end
  end
  assign ff_sl_intf.ff_occ = occ;
  assign ff_sl_intf.ff_ovrflw = ovrflw;
  assign ff_sl_intf.ff_undrflw = undrflw;
`endif
endmodule

// File: tb/tb_sync_ff.sv
// tb_sync_ff: scoreboard bench for sync_ff (DEPTH=16, DATA_W=8)
module tb_sync_ff;
  import sync_ff_pkg::*;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  logic clk_ir = 1'b0;
  logic rst_ih = 1'b1;
  ff_intf #(.DATA_W(DW), .DEPTH(DEPTH)) ff_if ();
  sync_ff #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_ir(clk_ir),
    .rst_ih(rst_ih),
    .ff_sl_intf(ff_if)
  );
  always #5 clk_ir = ~clk_ir;
  logic [DW-1:0] model[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd = '0;
  logic ovr_m = 1'b0;
  logic und_m = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic check_state(input string tag);
    check({tag, ".rd_data"}, 32'(ff_if.ff_rd_data), 32'(last_rd));
    check({tag, ".full"}, 32'(ff_if.ff_full), 32'(model.size() == DEPTH));
    check({tag, ".empty"}, 32'(ff_if.ff_empty), 32'(model.size() == 0));
`ifdef SYNC_FF_STATUS_EN
    check({tag, ".occ"}, 32'(ff_if.ff_occ), 32'(model.size()));
    check({tag, ".ovrflw"}, 32'(ff_if.ff_ovrflw), 32'(ovr_m));
    check({tag, ".undrflw"}, 32'(ff_if.ff_undrflw), 32'(und_m));
`endif
  endtask
  task automatic cyc(input string tag, input logic we, input logic [DW-1:0] wd, input logic re);
    logic wacc, racc;
    @(negedge clk_ir);
    ff_if.ff_wr_en = we;
    ff_if.ff_wr_data = wd;
    ff_if.ff_rd_en = re;
    wacc = we && model.size() < DEPTH;
    racc = re && model.size() != 0;
    if (we && !wacc) ovr_m = 1'b1;
    if (re && !racc) und_m = 1'b1;
    if (racc) exp_q.push_back(model.pop_front());
    if (wacc) model.push_back(wd);
    @(posedge clk_ir);
    #1;
    if (racc) last_rd = exp_q.pop_front();
    check_state(tag);
    ff_if.ff_wr_en = 1'b0;
    ff_if.ff_rd_en = 1'b0;
  endtask
  initial begin
    ff_if.ff_wr_en = 1'b0;
    ff_if.ff_wr_data = '0;
    ff_if.ff_rd_en = 1'b0;
    repeat (2) @(posedge clk_ir);
    #1;
    check_state("por");
    @(negedge clk_ir);
    rst_ih = 1'b0;
    for (int i = 0; i < 6; i++) cyc("pre_rst_wr", 1'b1, DW'(8'h10 + i), 1'b0);
    cyc("pre_rst_rd", 1'b0, '0, 1'b1);
    #2;
    rst_ih = 1'b1;
    #1;
    model.delete();
    exp_q.delete();
    last_rd = '0;
    ovr_m = 1'b0;
    und_m = 1'b0;
    check_state("mid_rst");
    @(posedge clk_ir);
    #1;
    check_state("rst_held");
    @(negedge clk_ir);
    rst_ih = 1'b0;
    cyc("post_rst_wr", 1'b1, 8'hA5, 1'b0);
    cyc("post_rst_rd", 1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) cyc("fill", 1'b1, DW'(i), 1'b0);
    cyc("drop_wr", 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 16; i++) cyc("drain", 1'b0, '0, 1'b1);
    cyc("both_empty", 1'b1, 8'h33, 1'b1);
    cyc("rd_33", 1'b0, '0, 1'b1);
    for (int i = 0; i < 16; i++) cyc("fill2", 1'b1, DW'(8'h80 + i), 1'b0);
    cyc("both_full", 1'b1, 8'h77, 1'b1);
    for (int i = 0; i < 15; i++) cyc("drain2", 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("empty_rd", 1'b0, '0, 1'b1);
    for (int i = 0; i < 40; i++) cyc("wrap", 1'b1, DW'(8'h40 + i), model.size() >= 2);
    while (model.size() != 0) cyc("wrap_drain", 1'b0, '0, 1'b1);
    cyc("idle", 1'b0, '0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
